// File: rtl/otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// otter_cu_fsm
//
// Multicycle control-unit state machine for the OTTER RV32I core.
// Each instruction is sequenced as FETCH -> EXEC (-> WB for loads), with an
// optional INTR cycle inserted at an instruction boundary. The FSM drives the
// write enables for the PC, register file, data memory and CSR file, and the
// immediate-type select for the immediate-generator mux.
//
// Loads and stores wait in EXEC for MEM_RDY. An 8-bit wait counter bounds
// that wait to MEM_TIMEOUT cycles. When the bound is reached the access is
// abandoned with a MEM_ERR pulse, and the PC still advances.
//
// Ports
//   CLK        in   system clock; all state updates on the rising edge
//   RST_N      in   asynchronous active-low reset
//   OPCODE     in   [6:0]  IR[6:0] of the current instruction
//   FUNCT3     in   [2:0]  IR[14:12]
//   INTR       in   level interrupt request
//   INT_EN     in   mstatus.MIE; an interrupt is taken only when this is 1
//   MEM_RDY    in   data memory has completed the load/store
//   PC_WE      out  PC register write enable
//   RF_WE      out  register file write enable
//   MEM_RDEN1  out  instruction memory read
//   MEM_RDEN2  out  data memory read
//   MEM_WE2    out  data memory write
//   CSR_WE     out  CSR write (csrrw)
//   INT_TAKEN  out  interrupt entry: PC loads mtvec, mepc is saved
//   MRET_EXEC  out  mret: PC loads mepc
//   ILLEGAL    out  one-cycle pulse, unsupported opcode/funct3 in EXEC
//   MEM_ERR    out  one-cycle pulse, load/store timeout
//   IMM_SEL    out  [2:0] 0=I 1=S 2=B 3=U 4=J; nonzero only in EXEC
//   DBG_STATE  out  [2:0] current FSM state encoding (debug observation)
//
// Handshake: the data-memory request (MEM_RDEN2 / MEM_WE2) is held high on
// every EXEC cycle of a load/store until MEM_RDY is sampled high in the same
// cycle. That cycle completes the access. Nothing is latched from MEM_RDY
// across cycles.
// ---------------------------------------------------------------------------
module otter_cu_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       INTR,
    input  logic       INT_EN,
    input  logic       MEM_RDY,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic       ILLEGAL,
    output logic       MEM_ERR,
    output logic [2:0] IMM_SEL,
    output logic [2:0] DBG_STATE
);

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate-type select encodings
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // SYSTEM funct3 values
    localparam logic [2:0] F3_PRIV   = 3'b000;  // mret
    localparam logic [2:0] F3_CSRRW  = 3'b001;

    // The timeout fires when the counter reaches this value. The counter
    // starts at 0 on EXEC entry, so the limit falls on the MEM_TIMEOUT-th
    // waiting cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic       instr_end;   // this cycle is the last of the instruction
    logic       wait_limit;  // wait counter has reached its last allowed value

    assign wait_limit = (wait_cnt_q == WAIT_LAST);
    assign DBG_STATE  = state_q;

    // -----------------------------------------------------------------------
    // State and wait-counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instr_end  = 1'b0;
        PC_WE      = 1'b0;
        RF_WE      = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        CSR_WE     = 1'b0;
        INT_TAKEN  = 1'b0;
        MRET_EXEC  = 1'b0;
        ILLEGAL    = 1'b0;
        MEM_ERR    = 1'b0;
        IMM_SEL    = IMM_I;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                MEM_RDEN1  = 1'b1;
                wait_cnt_d = 8'd0;   // every EXEC entry starts a fresh wait
                state_d    = ST_EXEC;
            end

            ST_EXEC: begin
                unique case (OPCODE)
                    OPC_LOAD, OPC_OP_IMM, OPC_JALR: IMM_SEL = IMM_I;
                    OPC_STORE:                      IMM_SEL = IMM_S;
                    OPC_BRANCH:                     IMM_SEL = IMM_B;
                    OPC_LUI, OPC_AUIPC:             IMM_SEL = IMM_U;
                    OPC_JAL:                        IMM_SEL = IMM_J;
                    default:                        IMM_SEL = IMM_I;
                endcase

                unique case (OPCODE)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        RF_WE     = 1'b1;
                        PC_WE     = 1'b1;
                        instr_end = 1'b1;
                    end

                    // Taken/not-taken is chosen by the datapath PC mux.
                    OPC_BRANCH: begin
                        PC_WE     = 1'b1;
                        instr_end = 1'b1;
                    end

                    OPC_STORE: begin
                        MEM_WE2 = 1'b1;
                        if (MEM_RDY) begin
                            PC_WE     = 1'b1;
                            instr_end = 1'b1;
                        end else if (wait_limit) begin
                            MEM_ERR   = 1'b1;
                            PC_WE     = 1'b1;
                            instr_end = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end

                    // A successful load retires in WB, so the PC is not
                    // written here. A timed-out load skips WB entirely.
                    OPC_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                        if (MEM_RDY) begin
                            state_d = ST_WB;
                        end else if (wait_limit) begin
                            MEM_ERR   = 1'b1;
                            PC_WE     = 1'b1;
                            instr_end = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end

                    OPC_SYSTEM: begin
                        PC_WE     = 1'b1;
                        instr_end = 1'b1;
                        if (FUNCT3 == F3_CSRRW) begin
                            CSR_WE = 1'b1;
                            RF_WE  = 1'b1;
                        end else if (FUNCT3 == F3_PRIV) begin
                            MRET_EXEC = 1'b1;
                        end else begin
                            ILLEGAL = 1'b1;
                        end
                    end

                    // Unsupported opcode: skip over it with no side effects.
                    default: begin
                        ILLEGAL   = 1'b1;
                        PC_WE     = 1'b1;
                        instr_end = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                RF_WE     = 1'b1;
                PC_WE     = 1'b1;
                instr_end = 1'b1;
            end

            // Always returns to FETCH, so at least one instruction runs
            // between two interrupt entries.
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WE     = 1'b1;
                state_d   = ST_FETCH;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Interrupts are only taken at an instruction boundary.
        if (instr_end) begin
            state_d = (INTR && INT_EN) ? ST_INTR : ST_FETCH;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_otter_cu_fsm
//
// Directed bench for otter_cu_fsm. The driver applies one input vector per
// clock and pushes the hand-computed output word for that cycle. The monitor
// pops one word on every falling edge and compares it with the DUT outputs.
//
// Expected word layout:
//   [15:13] state   [12] PC_WE   [11] RF_WE     [10] MEM_RDEN1
//   [9] MEM_RDEN2   [8] MEM_WE2  [7] CSR_WE     [6] INT_TAKEN
//   [5] MRET_EXEC   [4] ILLEGAL  [3] MEM_ERR    [2:0] IMM_SEL
// ---------------------------------------------------------------------------
module tb_otter_cu_fsm;

    localparam int W = 16;

    localparam logic [W-1:0] S_INIT  = 16'(0) << 13;
    localparam logic [W-1:0] S_FETCH = 16'(1) << 13;
    localparam logic [W-1:0] S_EXEC  = 16'(2) << 13;
    localparam logic [W-1:0] S_WB    = 16'(3) << 13;
    localparam logic [W-1:0] S_INTR  = 16'(4) << 13;
    localparam logic [W-1:0] PC   = 16'h1000;
    localparam logic [W-1:0] RF   = 16'h0800;
    localparam logic [W-1:0] RD1  = 16'h0400;
    localparam logic [W-1:0] RD2  = 16'h0200;
    localparam logic [W-1:0] WE2  = 16'h0100;
    localparam logic [W-1:0] CSR  = 16'h0080;
    localparam logic [W-1:0] IT   = 16'h0040;
    localparam logic [W-1:0] MRET = 16'h0020;
    localparam logic [W-1:0] ILL  = 16'h0010;
    localparam logic [W-1:0] ERR  = 16'h0008;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [6:0] OPCODE = '0;
    logic [2:0] FUNCT3 = '0;
    logic       INTR = 1'b0;
    logic       INT_EN = 1'b0;
    logic       MEM_RDY = 1'b0;
    logic       PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE;
    logic       INT_TAKEN, MRET_EXEC, ILLEGAL, MEM_ERR;
    logic [2:0] IMM_SEL, DBG_STATE;

    always #5 CLK = ~CLK;

    otter_cu_fsm #(.MEM_TIMEOUT(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
        .INTR(INTR), .INT_EN(INT_EN), .MEM_RDY(MEM_RDY),
        .PC_WE(PC_WE), .RF_WE(RF_WE), .MEM_RDEN1(MEM_RDEN1),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE),
        .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .ILLEGAL(ILLEGAL),
        .MEM_ERR(MEM_ERR), .IMM_SEL(IMM_SEL), .DBG_STATE(DBG_STATE)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           seq = 0;

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            int           t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {DBG_STATE, PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                 CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL, MEM_ERR, IMM_SEL};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_%0d: got %h expected %h", t, a, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic intr, input logic inten, input logic rdy,
                       input logic [W-1:0] exp);
        @(posedge CLK);
        #1;
        RST_N   = rst;
        OPCODE  = op;
        FUNCT3  = f3;
        INTR    = intr;
        INT_EN  = inten;
        MEM_RDY = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(seq);
        seq++;
    endtask

    // Reset pulled low between clock edges: outputs must clear immediately.
    task automatic cyc_async_rst(input logic [6:0] op, input logic [W-1:0] exp);
        @(posedge CLK);
        #1;
        OPCODE  = op;
        MEM_RDY = 1'b0;
        #1;
        RST_N = 1'b0;
        exp_q.push_back(exp);
        tag_q.push_back(seq);
        seq++;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic intr,
                       input logic inten, input logic rdy, input logic [W-1:0] exp);
        cyc(1'b1, op, f3, intr, inten, rdy, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset, then ADDI
        cyc(1'b0, OP_IMM, 3'd0, 1'b0, 1'b0, 1'b1, S_INIT);
        cyc(1'b0, OP_IMM, 3'd0, 1'b0, 1'b0, 1'b1, S_INIT);
        cyc(1'b1, OP_IMM, 3'd0, 1'b0, 1'b0, 1'b1, S_INIT);
        run(OP_IMM, 3'd0, 1'b0, 1'b0, 1'b1, S_FETCH | RD1);
        run(OP_IMM, 3'd0, 1'b0, 1'b0, 1'b1, S_EXEC | PC | RF | 16'd0);

        // LW: 3 wait cycles, then ready, then WB
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        for (int i = 0; i < 3; i++) run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_WB | RF | PC);

        // SW timeout: MEM_WE2 for 15 cycles, error on the 15th
        run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        for (int i = 0; i < 14; i++) run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | WE2 | 16'd1);
        run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | WE2 | ERR | PC | 16'd1);

        // SW completing after 2 wait cycles
        run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        for (int i = 0; i < 2; i++) run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | WE2 | 16'd1);
        run(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b1, S_EXEC | WE2 | PC | 16'd1);

        // BEQ with interrupt enabled, then with interrupt masked
        run(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, S_FETCH | RD1);
        run(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, S_EXEC | PC | 16'd2);
        run(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, S_INTR | IT | PC);
        run(OP_BR, 3'd0, 1'b1, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_BR, 3'd0, 1'b1, 1'b0, 1'b0, S_EXEC | PC | 16'd2);

        // LUI and JAL immediate types
        run(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC | RF | 16'd3);
        run(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC | RF | 16'd4);

        // Illegal opcode, mret, csrrw, illegal SYSTEM funct3
        run(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | ILL | PC);
        run(OP_SYS, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_SYS, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | MRET | PC);
        run(OP_SYS, 3'd1, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_SYS, 3'd1, 1'b0, 1'b0, 1'b0, S_EXEC | CSR | RF | PC);
        run(OP_SYS, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_SYS, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | ILL | PC);

        // LW with INTR raised mid-wait: taken only after WB, then no repeat
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_LOAD, 3'd2, 1'b1, 1'b1, 1'b0, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b1, 1'b1, 1'b1, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b1, 1'b1, 1'b0, S_WB | RF | PC);
        run(OP_LOAD, 3'd2, 1'b1, 1'b1, 1'b0, S_INTR | IT | PC);
        run(OP_IMM, 3'd0, 1'b1, 1'b1, 1'b0, S_FETCH | RD1);
        run(OP_IMM, 3'd0, 1'b0, 1'b1, 1'b0, S_EXEC | PC | RF | 16'd0);

        // Asynchronous reset mid-load wait, then a full timeout from a fresh count
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | RD2);
        cyc_async_rst(OP_LOAD, S_INIT);
        cyc(1'b0, OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_INIT);
        cyc(1'b1, OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_INIT);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);
        for (int i = 0; i < 14; i++) run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | RD2);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_EXEC | RD2 | ERR | PC);
        run(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, S_FETCH | RD1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multicycle control-unit state machine for the OTTER RV32I core.
- Sequences fetch, execute and writeback, and issues the write enables for the PC, register file, data memory and CSR file.
- Drives the immediate-type select for the immediate-generator mux.
- Handles load/store wait states against a data-memory ready handshake with a timeout, and takes interrupts only at instruction boundaries.

Parameters:
- MEM_TIMEOUT, 15: max EXEC cycles spent waiting for MEM_RDY before the access is abandoned; range 1..255.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- OPCODE  input  7  IR[6:0] of current instruction
- FUNCT3  input  3  IR[14:12]
- INTR  input  1  level interrupt request
- INT_EN  input  1  mstatus.MIE; interrupt is taken only if 1
- MEM_RDY  input  1  data memory has completed the load/store
- PC_WE  output  1  PC register write enable
- RF_WE  output  1  register file write enable
- MEM_RDEN1  output  1  instruction memory read
- MEM_RDEN2  output  1  data memory read
- MEM_WE2  output  1  data memory write
- CSR_WE  output  1  CSR write (csrrw)
- INT_TAKEN  output  1  interrupt entry: PC loads mtvec, mepc saved
- MRET_EXEC  output  1  mret: PC loads mepc
- ILLEGAL  output  1  one-cycle pulse, unsupported opcode in EXEC
- MEM_ERR  output  1  one-cycle pulse, load/store timeout
- IMM_SEL  output  3  0=I, 1=S, 2=B, 3=U, 4=J; valid in EXEC only, 0 elsewhere

Behaviour:
- States: INIT, FETCH, EXEC, WB, INTR. RST_N low forces INIT and clears the wait counter immediately, including mid-instruction.
- Outputs are combinational from state, OPCODE, FUNCT3 and MEM_RDY. In INIT every output is 0, so all outputs read 0 during and directly after reset.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: MEM_RDEN1=1. Next state is EXEC.
- EXEC, IMM_SEL by opcode:
  - LOAD 0000011, OP_IMM 0010011, JALR 1100111: I (0)
  - STORE 0100011: S (1)
  - BRANCH 1100011: B (2)
  - LUI 0110111, AUIPC 0010111: U (3)
  - JAL 1101111: J (4)
  - OP 0110011, SYSTEM 1110011, illegal: 0
- EXEC, OP, OP_IMM, LUI, AUIPC, JAL, JALR: RF_WE=1, PC_WE=1.
- EXEC, BRANCH: PC_WE=1 only. The branch condition is resolved in the datapath PC mux, not here.
- EXEC, STORE:
  - MEM_WE2=1 and held every cycle until MEM_RDY=1.
  - On the MEM_RDY cycle: PC_WE=1.
- EXEC, LOAD:
  - MEM_RDEN2=1 and held until MEM_RDY=1.
  - On the MEM_RDY cycle: next state is WB; PC_WE=0 in EXEC.
- EXEC, SYSTEM:
  - FUNCT3=001: CSR_WE=1, RF_WE=1, PC_WE=1.
  - FUNCT3=000: MRET_EXEC=1, PC_WE=1.
  - Any other FUNCT3 is illegal.
- EXEC, illegal opcode/funct3: ILLEGAL=1, PC_WE=1, no other writes.
- Wait counter: 8-bit, cleared on every entry to EXEC, increments on each EXEC cycle with a pending load/store and MEM_RDY=0.
  - Timeout is reached when the counter equals MEM_TIMEOUT-1 and MEM_RDY=0.
  - On that cycle: MEM_ERR=1, PC_WE=1, the memory strobe is still high, RF_WE=0. The instruction then completes without WB.
  - MEM_RDY=1 on that same cycle means success; no MEM_ERR.
- WB: RF_WE=1, PC_WE=1.
- End of instruction is any EXEC exit other than to WB, and WB itself.
  - Next state is INTR if INTR and INT_EN are both 1, otherwise FETCH.
  - INTR asserted mid-wait is not taken until the instruction ends.
- INTR: INT_TAKEN=1, PC_WE=1. Next state is FETCH; no back-to-back INTR without an intervening instruction.
- Latency:
  - ALU/branch/jump/CSR: 2 cycles.
  - Store: 2+W cycles, where W is the number of wait cycles.
  - Load: 3+W cycles.
  - Interrupt entry adds 1 cycle.

Test Plan:
- Reset then ADDI (0010011), MEM_RDY=1 -> INIT, then FETCH with MEM_RDEN1=1, then EXEC with IMM_SEL=0, RF_WE=1, PC_WE=1, then FETCH; all outputs 0 while RST_N=0.
- LW with MEM_RDY low 3 cycles then high -> MEM_RDEN2=1 for 4 EXEC cycles, then one WB cycle with RF_WE=1 and PC_WE=1; PC_WE=0 throughout EXEC.
- SW with MEM_RDY never high, MEM_TIMEOUT=15 -> MEM_WE2 high 15 cycles; on 15th cycle MEM_ERR=1 and PC_WE=1; next state FETCH; RF_WE never 1.
- BEQ with INTR=1, INT_EN=1 -> EXEC with IMM_SEL=2, PC_WE=1, RF_WE=0, then INTR state with INT_TAKEN=1 and PC_WE=1, then FETCH. With INT_EN=0, FETCH follows EXEC directly.
- Opcode 1111111, then SYSTEM FUNCT3=000, then SYSTEM FUNCT3=001 -> ILLEGAL pulse with PC_WE=1; then MRET_EXEC=1 with PC_WE=1; then CSR_WE=1, RF_WE=1, PC_WE=1.
- RST_N dropped asynchronously mid-load wait -> all outputs 0 before the next CLK edge; after release, INIT then FETCH, with the counter restarting from 0.
